// File: rtl/fetch_pkg.sv
// fetch_pkg: state encoding and constants shared by the fetch stage.
package fetch_pkg;
  typedef enum logic {FETCH, HALTED} state_t;
  localparam logic [15:0] PC_STEP = 16'd2;
  localparam logic [15:0] DEFAULT_HALT_WORD = 16'hFFFF;
endpackage

// File: rtl/instruction_fetch_program_counter.sv
// ProgramCounter: halfword-aligned PC with redirect, advance and hold.
module ProgramCounter
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [15:0] target,
  input  logic        advance,
  output logic [15:0] pc
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= {RESET_PC[15:1], 1'b0};
    else pc <= redirect ? {target[15:1], 1'b0} : advance ? pc + PC_STEP : pc;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch FSM, IF/ID register and saturating fetch counter.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic        Clock,
  input  logic        Reset_n,
  output logic [15:0] Address,
  input  logic [15:0] Instruction,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [15:0] RedirectTarget,
  output logic [15:0] InstrOut,
  output logic [15:0] PCOut,
  output logic        InstrValid,
  output logic        Halted,
  output logic [15:0] FetchCount
);
  state_t state;
  logic   advance;
  assign advance = state == FETCH && !Stall && Instruction != HALT_WORD;
  ProgramCounter #(.RESET_PC(RESET_PC)) u_pc (
    .clk     (Clock),
    .rst_n   (Reset_n),
    .redirect(Redirect),
    .target  (RedirectTarget),
    .advance (advance),
    .pc      (Address)
  );
  // Redirect flushes and restarts fetch regardless of stall or halt.
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      state      <= FETCH;
      InstrOut   <= 16'h0000;
      PCOut      <= 16'h0000;
      InstrValid <= 1'b0;
      Halted     <= 1'b0;
      FetchCount <= 16'h0000;
    end else if (Redirect) begin
      state      <= FETCH;
      InstrValid <= 1'b0;
      Halted     <= 1'b0;
    end else if (!Stall) begin
      if (state == FETCH) begin
        InstrOut   <= Instruction;
        PCOut      <= Address;
        InstrValid <= 1'b1;
        FetchCount <= FetchCount + {15'd0, FetchCount != 16'hFFFF};
        if (Instruction == HALT_WORD) begin
          state  <= HALTED;
          Halted <= 1'b1;
        end
      end else InstrValid <= 1'b0;
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed stimulus checked against a behavioural fetch model.
module tb_instruction_fetch;
  logic        Clock = 0, Reset_n = 0, Stall = 0, Redirect = 0;
  logic [15:0] RedirectTarget = 0;
  logic [15:0] Address, Instruction, InstrOut, PCOut, FetchCount;
  logic        InstrValid, Halted;
  logic [15:0] w_addr, w_instr, w_io, w_po, w_cnt;
  logic        w_valid, w_halted;
  logic [15:0] mem [0:32767];
  int total = 0, bad = 0;
  logic [15:0] m_pc = 0, m_io = 0, m_po = 0, m_cnt = 0;
  logic        m_valid = 0, m_halt = 0;

  always #5 Clock = ~Clock;
  assign Instruction = mem[Address[15:1]];
  assign w_instr = mem[w_addr[15:1]];

  instruction_fetch dut (
    .Clock(Clock), .Reset_n(Reset_n), .Address(Address), .Instruction(Instruction),
    .Stall(Stall), .Redirect(Redirect), .RedirectTarget(RedirectTarget),
    .InstrOut(InstrOut), .PCOut(PCOut), .InstrValid(InstrValid), .Halted(Halted),
    .FetchCount(FetchCount)
  );
  instruction_fetch #(.RESET_PC(16'hFFFC)) wrap (
    .Clock(Clock), .Reset_n(Reset_n), .Address(w_addr), .Instruction(w_instr),
    .Stall(1'b0), .Redirect(1'b0), .RedirectTarget(16'h0000),
    .InstrOut(w_io), .PCOut(w_po), .InstrValid(w_valid), .Halted(w_halted),
    .FetchCount(w_cnt)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one accepted word per unstalled edge until a halt word is taken.
  always @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      m_pc = 0; m_io = 0; m_po = 0; m_cnt = 0; m_valid = 0; m_halt = 0;
    end else if (Redirect) begin
      m_pc = RedirectTarget & 16'hFFFE; m_valid = 0; m_halt = 0;
    end else if (!Stall) begin
      if (m_halt) m_valid = 0;
      else begin
        m_io = mem[m_pc / 2]; m_po = m_pc; m_valid = 1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
        if (m_io == 16'hFFFF) m_halt = 1;
        else m_pc = 16'((32'(m_pc) + 2) % 65536);
      end
    end

  always @(negedge Clock) begin
    chk("model_addr", Address, m_pc);
    chk("model_instr", InstrOut, m_io);
    chk("model_pcout", PCOut, m_po);
    chk("model_valid", {15'd0, InstrValid}, {15'd0, m_valid});
    chk("model_halted", {15'd0, Halted}, {15'd0, m_halt});
    chk("model_count", FetchCount, m_cnt);
  end

  task automatic cyc(input logic s, input logic r, input logic [15:0] t);
    Stall = s; Redirect = r; RedirectTarget = t;
    @(posedge Clock); #1;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'(i) ^ 16'h1000;
    mem[0] = 16'h1234;
    mem[5] = 16'hFFFF;
    repeat (2) @(posedge Clock);
    #1;
    chk("wrap_reset", w_addr, 16'hFFFC);
    chk("reset_addr", Address, 16'h0000);
    Reset_n = 1;
    cyc(0, 0, 0);
    chk("first_instr", InstrOut, 16'h1234);
    chk("first_pcout", PCOut, 16'h0000);
    chk("first_valid", {15'd0, InstrValid}, 16'd1);
    chk("first_addr", Address, 16'h0002);
    chk("wrap_fffe", w_addr, 16'hFFFE);
    cyc(0, 0, 0);
    chk("second_addr", Address, 16'h0004);
    chk("wrap_0000", w_addr, 16'h0000);
    cyc(0, 0, 0);
    chk("third_addr", Address, 16'h0006);
    repeat (3) cyc(1, 0, 0);
    chk("stall_addr", Address, 16'h0006);
    chk("stall_count", FetchCount, 16'd3);
    chk("stall_pcout", PCOut, 16'h0004);
    cyc(0, 0, 0);
    chk("resume_pcout", PCOut, 16'h0006);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("halt_instr", InstrOut, 16'hFFFF);
    chk("halt_pcout", PCOut, 16'h000A);
    chk("halt_valid", {15'd0, InstrValid}, 16'd1);
    chk("halt_flag", {15'd0, Halted}, 16'd1);
    chk("halt_addr", Address, 16'h000A);
    chk("halt_count", FetchCount, 16'd6);
    cyc(0, 0, 0);
    chk("halted_valid", {15'd0, InstrValid}, 16'd0);
    chk("halted_addr", Address, 16'h000A);
    chk("halted_count", FetchCount, 16'd6);
    cyc(0, 1, 16'h0000);
    chk("unhalt_flag", {15'd0, Halted}, 16'd0);
    chk("unhalt_addr", Address, 16'h0000);
    cyc(1, 1, 16'h0021);
    chk("redir_addr", Address, 16'h0020);
    chk("redir_valid", {15'd0, InstrValid}, 16'd0);
    cyc(0, 0, 0);
    chk("redir_instr", InstrOut, 16'h1010);
    chk("redir_pcout", PCOut, 16'h0020);
    chk("redir_valid1", {15'd0, InstrValid}, 16'd1);
    chk("redir_count", FetchCount, 16'd7);
    Stall = 1;
    @(posedge Clock); #2;
    Reset_n = 0;
    #1;
    chk("areset_addr", Address, 16'h0000);
    chk("areset_instr", InstrOut, 16'h0000);
    chk("areset_pcout", PCOut, 16'h0000);
    chk("areset_valid", {15'd0, InstrValid}, 16'd0);
    chk("areset_count", FetchCount, 16'd0);
    @(posedge Clock); #1;
    Reset_n = 1;
    cyc(0, 0, 0);
    chk("refetch_instr", InstrOut, 16'h1234);
    chk("refetch_addr", Address, 16'h0002);
    repeat (4) cyc(0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_WORD, 16'hFFFF, instruction encoding that halts fetch.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- Clock, in, 1, the single clock; all state updates on its rising edge.
- Reset_n, in, 1, asynchronous active-low reset.
- Address, out, 16, byte address to the instruction memory; equals PC combinationally.
- Instruction, in, 16, word returned combinationally by the instruction memory for Address.
- Stall, in, 1, downstream not ready; hold all state.
- Redirect, in, 1, branch/jump taken this cycle.
- RedirectTarget, in, 16, new PC when Redirect=1.
- InstrOut, out, 16, registered fetched instruction (IF/ID register).
- PCOut, out, 16, address InstrOut was fetched from.
- InstrValid, out, 1, InstrOut/PCOut hold a valid instruction.
- Halted, out, 1, fetch stopped on HALT_WORD.
- FetchCount, out, 16, number of instructions accepted since reset, saturating.
REQ-003 One clock and one reset SHALL exist; Reset_n is asynchronous and active-low.

Function
REQ-004 Address SHALL equal the PC register at all times; bit 0 of PC SHALL always be 0.
REQ-005 States SHALL be FETCH and HALTED; reset enters FETCH.
REQ-006 FETCH, Stall=0, Redirect=0: on the rising edge, InstrOut<=Instruction, PCOut<=PC, InstrValid<=1, PC<=PC+2, FetchCount<=FetchCount+1.
REQ-007 PC increment SHALL wrap modulo 2^16 (16'hFFFE -> 16'h0000).
REQ-008 Latency SHALL be one cycle: a word presented at Address in cycle N appears on InstrOut in cycle N+1.
REQ-009 Stall=1, Redirect=0: PC, InstrOut, PCOut, InstrValid, FetchCount and state SHALL hold.
REQ-010 Redirect=1 SHALL take priority over Stall and state: PC<={RedirectTarget[15:1],1'b0}, InstrValid<=0 (flush), state<=FETCH, Halted<=0; InstrOut/PCOut hold; FetchCount unchanged.
REQ-011 In FETCH, when an accepted word (per REQ-006) equals HALT_WORD, it SHALL be latched with InstrValid=1 and the state SHALL go to HALTED; PC SHALL NOT advance.
REQ-012 In HALTED: Halted=1; PC frozen; FetchCount frozen; on the first edge with Stall=0, InstrValid<=0; with Stall=1, InstrValid holds.
REQ-013 FetchCount SHALL saturate at 16'hFFFF.
REQ-014 Halted SHALL be registered and asserted from the cycle after the HALT_WORD edge.

Reset
REQ-015 Reset_n=0 SHALL immediately force PC=RESET_PC, InstrOut=16'h0000, PCOut=16'h0000, InstrValid=0, Halted=0, FetchCount=0, state=FETCH, independent of Clock.
REQ-016 Reset asserted mid-stall or mid-halt SHALL give the same result as REQ-015.
REQ-017 The first fetch SHALL occur on the first rising edge after Reset_n deasserts.

Structure
REQ-018 Shared package fetch_pkg SHALL hold the state encoding, PC_STEP=2 and the HALT_WORD default.
REQ-019 The PC register with its increment, redirect and hold muxing SHALL be the sub-module ProgramCounter; the FSM, IF/ID register and counter SHALL stay in instruction_fetch.

Verification
REQ-020 The bench SHALL drive Instruction from a memory model matching InstructionMemory and SHALL cover:
- Reset release, memory word at 0x0000 = 16'h1234, Stall=0 -> Address 0000,0002,0004 on consecutive cycles; InstrOut=1234, PCOut=0000, InstrValid=1 after the first edge.
- Stall=1 for 3 cycles at PC=0x0006 -> Address stays 0006; InstrOut, PCOut, FetchCount unchanged; fetch resumes at 0006.
- Redirect=1, RedirectTarget=16'h0021, with Stall=1 -> next Address=0020; InstrValid=0 for one cycle; then the word at 0020 with PCOut=0020.
- HALT_WORD at 0x000A -> InstrOut=FFFF, InstrValid=1, Halted=1, Address frozen at 000A; InstrValid=0 next unstalled cycle; Redirect to 0000 clears Halted.
- RESET_PC=16'hFFFC -> Address FFFC, FFFE, 0000 (wrap).
- Reset_n pulsed low mid-stall between clock edges -> all outputs at reset values immediately, before the next edge.
